// File: rtl/fifo_wconv.sv
// Width-converting FIFO: packs IW-bit writes into IW*RATIO-bit words.
// Show-ahead read side, sticky overflow/underflow flags, synchronous flush.
module fifo_wconv #(
    parameter int IW        = 8,
    parameter int RATIO     = 4,
    parameter int DEPTH     = 4,
    parameter int AFULL_TH  = 3,
    parameter int MSB_FIRST = 0
) (
    input  logic                      sclk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic [IW-1:0]             wdata_i,
    input  logic                      wr_i,
    output logic [IW*RATIO-1:0]       rdata_o,
    input  logic                      rd_i,
    output logic                      empty_o,
    output logic                      full_o,
    output logic                      afull_o,
    output logic [$clog2(DEPTH):0]    level_o,
    output logic                      wr_ovf_o,
    output logic                      rd_udf_o
);

    localparam int OW    = IW * RATIO;
    localparam int SLOTS = DEPTH * RATIO;
    localparam int SW    = $clog2(SLOTS);
    localparam int WPW   = SW + 1;
    localparam int RPW   = $clog2(DEPTH) + 1;
    localparam int RB    = $clog2(RATIO);

    localparam logic [WPW-1:0] SLOTS_V = WPW'(SLOTS);
    localparam logic [RPW-1:0] AF_V    = RPW'(AFULL_TH);

    logic [IW-1:0]  r_mem [SLOTS];
    logic [WPW-1:0] r_wptr;
    logic [RPW-1:0] r_rptr;
    logic           r_ovf;
    logic           r_udf;

    logic [WPW-1:0] w_diff;
    logic [RPW-1:0] w_level;
    logic           w_wr_ok;
    logic           w_rd_ok;
    logic [SW-1:0]  w_slot;
    logic [OW-1:0]  w_rdata;

    // Pointers carry one extra wrap bit so full and empty are distinguishable
    assign w_level  = r_wptr[WPW-1:RB] - r_rptr;
    assign w_diff   = r_wptr - {r_rptr, {RB{1'b0}}};
    assign empty_o  = (w_level == '0);
    assign full_o   = (w_diff == SLOTS_V);
    assign afull_o  = (w_level >= AF_V);
    assign level_o  = w_level;
    assign wr_ovf_o = r_ovf;
    assign rd_udf_o = r_udf;
    assign w_wr_ok  = wr_i & ~full_o;
    assign w_rd_ok  = rd_i & ~empty_o;

    always_ff @(posedge sclk or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_ovf  <= 1'b0;
            r_udf  <= 1'b0;
            for (int i = 0; i < SLOTS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (clr) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_ovf  <= 1'b0;
            r_udf  <= 1'b0;
        end else begin
            if (w_wr_ok) begin
                r_mem[r_wptr[SW-1:0]] <= wdata_i;
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_rd_ok) begin
                r_rptr <= r_rptr + 1'b1;
            end
            if (wr_i && full_o) begin
                r_ovf <= 1'b1;
            end
            if (rd_i && empty_o) begin
                r_udf <= 1'b1;
            end
        end
    end

    always_comb begin
        w_rdata = '0;
        w_slot  = '0;
        for (int k = 0; k < RATIO; k++) begin
            w_slot = {r_rptr[RPW-2:0], RB'(k)};
            if (MSB_FIRST != 0) begin
                w_rdata[OW-1-IW*k -: IW] = r_mem[w_slot];
            end else begin
                w_rdata[IW*k +: IW] = r_mem[w_slot];
            end
        end
    end

    assign rdata_o = w_rdata;

endmodule

// File: tb/tb_fifo_wconv.sv
// Directed bench for fifo_wconv; LSB-first and MSB-first instances
// share one stimulus stream.
module tb_fifo_wconv;

    logic        sclk = 1'b0;
    logic        rst;
    logic        clr;
    logic [7:0]  wdata_i;
    logic        wr_i;
    logic        rd_i;
    logic [31:0] rdata_a, rdata_b;
    logic        empty_a, full_a, afull_a, ovf_a, udf_a;
    logic        empty_b, full_b, afull_b, ovf_b, udf_b;
    logic [2:0]  level_a, level_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 sclk = ~sclk;

    fifo_wconv #(.IW(8), .RATIO(4), .DEPTH(4), .AFULL_TH(3), .MSB_FIRST(0)) u_a (
        .sclk(sclk), .rst(rst), .clr(clr), .wdata_i(wdata_i), .wr_i(wr_i),
        .rdata_o(rdata_a), .rd_i(rd_i), .empty_o(empty_a), .full_o(full_a),
        .afull_o(afull_a), .level_o(level_a), .wr_ovf_o(ovf_a), .rd_udf_o(udf_a)
    );

    fifo_wconv #(.IW(8), .RATIO(4), .DEPTH(4), .AFULL_TH(3), .MSB_FIRST(1)) u_b (
        .sclk(sclk), .rst(rst), .clr(clr), .wdata_i(wdata_i), .wr_i(wr_i),
        .rdata_o(rdata_b), .rd_i(rd_i), .empty_o(empty_b), .full_o(full_b),
        .afull_o(afull_b), .level_o(level_b), .wr_ovf_o(ovf_b), .rd_udf_o(udf_b)
    );

    task automatic tick();
        @(posedge sclk);
        #1;
    endtask

    task automatic wr_byte(input logic [7:0] d);
        wdata_i = d;
        wr_i    = 1'b1;
        tick();
        wr_i    = 1'b0;
    endtask

    task automatic pop();
        rd_i = 1'b1;
        tick();
        rd_i = 1'b0;
    endtask

    task automatic flush();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    function automatic logic [7:0] sbyte(input int i);
        return 8'((i * 3 + 1) & 255);
    endfunction

    task automatic test_reset();
        rst = 1'b1; clr = 1'b0; wr_i = 1'b0; rd_i = 1'b0; wdata_i = '0;
        #12;
        rst = 1'b0;
        tick();
        n_cmp++; if (empty_a !== 1'b1) begin n_err++; $display("FAIL rst_empty got %b want 1", empty_a); end
        n_cmp++; if (full_a !== 1'b0) begin n_err++; $display("FAIL rst_full got %b want 0", full_a); end
        n_cmp++; if (afull_a !== 1'b0) begin n_err++; $display("FAIL rst_afull got %b want 0", afull_a); end
        n_cmp++; if (level_a !== 3'd0) begin n_err++; $display("FAIL rst_level got %0d want 0", level_a); end
        n_cmp++; if (rdata_a !== 32'h0) begin n_err++; $display("FAIL rst_rdata got %h want 0", rdata_a); end
        n_cmp++; if ({ovf_a, udf_a} !== 2'b00) begin n_err++; $display("FAIL rst_flags got %b want 00", {ovf_a, udf_a}); end
    endtask

    task automatic test_pack();
        wr_byte(8'h11);
        wr_byte(8'h22);
        wr_byte(8'h33);
        n_cmp++; if (empty_a !== 1'b1) begin n_err++; $display("FAIL pack_partial_empty got %b want 1", empty_a); end
        wr_byte(8'h44);
        n_cmp++; if (empty_a !== 1'b0) begin n_err++; $display("FAIL pack_empty got %b want 0", empty_a); end
        n_cmp++; if (level_a !== 3'd1) begin n_err++; $display("FAIL pack_level got %0d want 1", level_a); end
        n_cmp++; if (rdata_a !== 32'h44332211) begin n_err++; $display("FAIL pack_lsb got %h want 44332211", rdata_a); end
        n_cmp++; if (rdata_b !== 32'h11223344) begin n_err++; $display("FAIL pack_msb got %h want 11223344", rdata_b); end
        pop();
        n_cmp++; if (empty_a !== 1'b1) begin n_err++; $display("FAIL pack_pop_empty got %b want 1", empty_a); end
        flush();
    endtask

    task automatic test_full();
        for (int i = 0; i < 16; i++) begin
            wr_byte(8'(i));
            if (i == 7) begin
                n_cmp++; if (afull_a !== 1'b0) begin n_err++; $display("FAIL afull_l2 got %b want 0", afull_a); end
            end
            if (i == 11) begin
                n_cmp++; if (afull_a !== 1'b1) begin n_err++; $display("FAIL afull_l3 got %b want 1", afull_a); end
                n_cmp++; if (full_a !== 1'b0) begin n_err++; $display("FAIL full_l3 got %b want 0", full_a); end
            end
        end
        n_cmp++; if (full_a !== 1'b1) begin n_err++; $display("FAIL full got %b want 1", full_a); end
        n_cmp++; if (level_a !== 3'd4) begin n_err++; $display("FAIL full_level got %0d want 4", level_a); end
        n_cmp++; if (afull_a !== 1'b1) begin n_err++; $display("FAIL full_afull got %b want 1", afull_a); end
        wr_byte(8'hFF);
        n_cmp++; if (ovf_a !== 1'b1) begin n_err++; $display("FAIL ovf got %b want 1", ovf_a); end
        n_cmp++; if (level_a !== 3'd4) begin n_err++; $display("FAIL ovf_level got %0d want 4", level_a); end
        for (int w = 0; w < 4; w++) begin
            logic [31:0] exp;
            exp = {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)};
            n_cmp++; if (rdata_a !== exp) begin n_err++; $display("FAIL full_rd%0d got %h want %h", w, rdata_a, exp); end
            pop();
        end
        n_cmp++; if (empty_a !== 1'b1) begin n_err++; $display("FAIL full_drain_empty got %b want 1", empty_a); end
        n_cmp++; if (ovf_a !== 1'b1) begin n_err++; $display("FAIL ovf_sticky got %b want 1", ovf_a); end
        flush();
    endtask

    task automatic test_underflow();
        pop();
        n_cmp++; if (udf_a !== 1'b1) begin n_err++; $display("FAIL udf got %b want 1", udf_a); end
        n_cmp++; if (level_a !== 3'd0) begin n_err++; $display("FAIL udf_level got %0d want 0", level_a); end
        tick();
        n_cmp++; if (udf_a !== 1'b1) begin n_err++; $display("FAIL udf_sticky got %b want 1", udf_a); end
        wr_byte(8'h5A); wr_byte(8'h5B); wr_byte(8'h5C); wr_byte(8'h5D);
        n_cmp++; if (rdata_a !== 32'h5D5C5B5A) begin n_err++; $display("FAIL udf_ptr got %h want 5d5c5b5a", rdata_a); end
        flush();
        n_cmp++; if (udf_a !== 1'b0) begin n_err++; $display("FAIL udf_clr got %b want 0", udf_a); end
    endtask

    task automatic test_simul();
        for (int i = 0; i < 16; i++) wr_byte(8'(i));
        wdata_i = 8'hAA; wr_i = 1'b1; rd_i = 1'b1;
        tick();
        wr_i = 1'b0; rd_i = 1'b0;
        n_cmp++; if (level_a !== 3'd3) begin n_err++; $display("FAIL simfull_level got %0d want 3", level_a); end
        n_cmp++; if (ovf_a !== 1'b1) begin n_err++; $display("FAIL simfull_ovf got %b want 1", ovf_a); end
        n_cmp++; if (rdata_a !== 32'h07060504) begin n_err++; $display("FAIL simfull_head got %h want 07060504", rdata_a); end
        pop(); pop(); pop();
        n_cmp++; if ({empty_a, level_a} !== 4'b1_000) begin n_err++; $display("FAIL simfull_noaa got %b want 1000", {empty_a, level_a}); end
        flush();
        wr_byte(8'h01); wr_byte(8'h02); wr_byte(8'h03);
        wdata_i = 8'h04; wr_i = 1'b1; rd_i = 1'b1;
        tick();
        wr_i = 1'b0; rd_i = 1'b0;
        n_cmp++; if (udf_a !== 1'b1) begin n_err++; $display("FAIL simempty_udf got %b want 1", udf_a); end
        n_cmp++; if (level_a !== 3'd1) begin n_err++; $display("FAIL simempty_level got %0d want 1", level_a); end
        n_cmp++; if (rdata_a !== 32'h04030201) begin n_err++; $display("FAIL simempty_data got %h want 04030201", rdata_a); end
        flush();
    endtask

    task automatic test_stream();
        int w = 0;
        for (int i = 0; i < 40; i++) begin
            wdata_i = sbyte(i);
            wr_i    = 1'b1;
            rd_i    = 1'b0;
            if (i >= 4 && (i % 4) == 0) begin
                logic [31:0] exp;
                exp = {sbyte(4*w+3), sbyte(4*w+2), sbyte(4*w+1), sbyte(4*w)};
                n_cmp++; if (rdata_a !== exp) begin n_err++; $display("FAIL stream_w%0d got %h want %h", w, rdata_a, exp); end
                rd_i = 1'b1;
                w++;
            end
            tick();
        end
        wr_i = 1'b0;
        while (w < 10) begin
            logic [31:0] exp;
            exp = {sbyte(4*w+3), sbyte(4*w+2), sbyte(4*w+1), sbyte(4*w)};
            n_cmp++; if (rdata_a !== exp) begin n_err++; $display("FAIL stream_w%0d got %h want %h", w, rdata_a, exp); end
            rd_i = 1'b1;
            tick();
            rd_i = 1'b0;
            w++;
        end
        n_cmp++; if (empty_a !== 1'b1) begin n_err++; $display("FAIL stream_empty got %b want 1", empty_a); end
        n_cmp++; if ({ovf_a, udf_a} !== 2'b00) begin n_err++; $display("FAIL stream_flags got %b want 00", {ovf_a, udf_a}); end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 9; i++) wr_byte(8'h80 + 8'(i));
        n_cmp++; if (level_a !== 3'd2) begin n_err++; $display("FAIL flush_pre_level got %0d want 2", level_a); end
        flush();
        n_cmp++; if ({empty_a, level_a} !== 4'b1_000) begin n_err++; $display("FAIL flush_clr got %b want 1000", {empty_a, level_a}); end
        wr_byte(8'hA1); wr_byte(8'hB2); wr_byte(8'hC3); wr_byte(8'hD4);
        n_cmp++; if (rdata_a !== 32'hD4C3B2A1) begin n_err++; $display("FAIL flush_word got %h want d4c3b2a1", rdata_a); end
        for (int i = 0; i < 5; i++) wr_byte(8'h90 + 8'(i));
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if ({empty_a, level_a} !== 4'b1_000) begin n_err++; $display("FAIL arst_level got %b want 1000", {empty_a, level_a}); end
        n_cmp++; if (rdata_a !== 32'h0) begin n_err++; $display("FAIL arst_rdata got %h want 0", rdata_a); end
        #1;
        rst = 1'b0;
        tick();
        wr_byte(8'h0A); wr_byte(8'h0B); wr_byte(8'h0C); wr_byte(8'h0D);
        n_cmp++; if (rdata_a !== 32'h0D0C0B0A) begin n_err++; $display("FAIL arst_word got %h want 0d0c0b0a", rdata_a); end
        n_cmp++; if (rdata_b !== 32'h0A0B0C0D) begin n_err++; $display("FAIL arst_word_msb got %h want 0a0b0c0d", rdata_b); end
    endtask

    initial begin
        test_reset();
        test_pack();
        test_full();
        test_underflow();
        test_simul();
        test_stream();
        test_flush();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_wconv.md
Name: fifo_wconv

Overview:
Parametrised width-converting FIFO, narrow write side to wide read side. It is the generalised successor of the team's fixed 8-to-32 packer. Writes of IW bits are packed into OW = IW*RATIO-bit words, with configurable depth and sub-word order. Adds overflow/underflow protection, sticky error flags, fill level, almost-full and a synchronous flush. It sits between byte-serial receivers (UART/RS-232 RX) and word-wide register/bus logic.

Parameters:
IW, 8, write-side data width in bits.
RATIO, 4, sub-words per output word; power of 2, >=2.
DEPTH, 4, storage depth in complete output words; power of 2, >=2.
AFULL_TH, 3, afull_o asserts when level_o >= AFULL_TH; range 1..DEPTH.
MSB_FIRST, 0, 0: first written sub-word lands in rdata_o[IW-1:0]; 1: first written sub-word lands in the top IW bits.

Ports:
sclk  in  1  clock; all state on rising edge
rst  in  1  asynchronous reset, active-high
clr  in  1  synchronous flush; clears pointers and error flags
wdata_i  in  IW  write data
wr_i  in  1  write strobe, one sub-word per cycle
rdata_o  out  IW*RATIO  head word, show-ahead, valid while empty_o=0
rd_i  in  1  read strobe; pops head word
empty_o  out  1  no complete word stored
full_o  out  1  all DEPTH*RATIO sub-word slots occupied
afull_o  out  1  level_o >= AFULL_TH
level_o  out  $clog2(DEPTH)+1  number of complete words stored
wr_ovf_o  out  1  sticky: write attempted while full
rd_udf_o  out  1  sticky: read attempted while empty

Behaviour:
- Storage is DEPTH*RATIO sub-word slots. Write pointer wptr is $clog2(DEPTH*RATIO)+1 bits. Read pointer rptr is $clog2(DEPTH)+1 bits, in word units. The extra MSB is the wrap bit.
- level = wptr[MSB:$clog2(RATIO)] - rptr, modulo arithmetic. empty_o = (level==0). full_o = (wptr - rptr*RATIO) == DEPTH*RATIO. All flags are combinational from registered pointers.
- A partially filled word does not count in level and does not clear empty_o.
- Accepted write (wr_i & !full_o): slot wptr[low bits] <= wdata_i; wptr+1. Wraps naturally at 2*DEPTH*RATIO.
- Accepted read (rd_i & !empty_o): rptr+1. rdata_o changes to the next word in the same cycle the pointer updates.
- rdata_o is combinational from storage at rptr. With MSB_FIRST=0, slot k of the word maps to bits [IW*k+IW-1 : IW*k]. With MSB_FIRST=1, slot k maps to bits [OW-1-IW*k : OW-IW-IW*k].
- Latency: the write completing a word makes empty_o=0 and shows the word on rdata_o on the next cycle.
- Write while full: data dropped, wptr and storage unchanged, wr_ovf_o <= 1.
- Read while empty: rptr unchanged, rd_udf_o <= 1.
- Simultaneous wr_i and rd_i: both are evaluated against pre-edge flags.
  - At full, the write is dropped even though the read frees space.
  - At empty, the read is ignored even if this write completes a word.
- clr=1: wptr, rptr and both error flags go to 0 next edge; storage contents are don't-care. clr overrides wr_i/rd_i in the same cycle.
- rst=1 (async, any time): wptr=0, rptr=0, wr_ovf_o=0, rd_udf_o=0, storage cleared to 0.
- Reset values: empty_o=1, full_o=0, afull_o=0, level_o=0, rdata_o=0.
- No state machine beyond pointers and flags; no X may propagate to outputs after reset.

Test Plan:
- Defaults; write 0x11,0x22,0x33,0x44 on consecutive cycles -> empty_o=1 through the 4th write edge. Next cycle empty_o=0, level_o=1, rdata_o=0x44332211. Repeat with MSB_FIRST=1 -> rdata_o=0x11223344.
- Write bytes 0x00..0x0F -> full_o=1, level_o=4, afull_o=1 from level 3. 17th write 0xFF -> dropped, wr_ovf_o=1. Reading 4 words returns 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C, then empty_o=1.
- From empty, pulse rd_i -> rd_udf_o=1, level_o=0, pointers unchanged. Flag stays 1 until clr, then 0.
- At full, assert wr_i(0xAA) and rd_i together -> one word popped, level_o=3, 0xAA not stored, wr_ovf_o=1. At level 0 with 3 bytes pending, write the 4th byte with rd_i -> read ignored, rd_udf_o=1, level_o=1.
- Stream 40 bytes with a read every 4th cycle after the first word -> exercises pointer wrap twice. All 10 words read in order, no flags set, final empty_o=1.
- Mid-stream (level 2, 1 partial byte), pulse clr -> next cycle empty_o=1, level_o=0. Then write 4 bytes -> correct word. Repeat with async rst asserted between clock edges -> outputs reset immediately, without waiting for a clock edge.
